// File: rtl/api_slave.sv
// api_slave: chip-side responder for the load/sck/mosi/miso API daisy chain
module api_slave #(
   parameter int         WORK_BITS = 736,
   parameter int         RES_DEPTH = 4,
   parameter logic [7:0] CHIP_ID   = 8'h00
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 sck,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 work_vld,
   output logic [WORK_BITS-1:0] work_dat,
   input  logic                 work_rdy,
   input  logic                 res_wr_en,
   input  logic [31:0]          res_din,
   output logic                 res_full,
   output logic [1:0]           err,
   input  logic                 err_clr
);
   localparam int              AW       = $clog2(RES_DEPTH);
   localparam int              LW       = $clog2(RES_DEPTH) + 1;
   localparam logic [9:0]      FULL_CNT = 10'(WORK_BITS);
   localparam logic [LW-1:0]   DEPTH    = LW'(RES_DEPTH);

   typedef enum logic [1:0] {ARM, IDLE, SHIFT, LATCH} state_t;
   state_t state, state_nxt;

   logic [2:0]           load_sy, sck_sy;
   logic [1:0]           mosi_sy;
   logic                 load_rise, load_fall, sck_rise, sck_fall;
   logic [WORK_BITS-1:0] sr;
   logic [9:0]           bit_cnt;
   logic [7:0]           frame_cnt;
   logic [31:0]          mem [RES_DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic [LW-1:0]        level, level_nxt;
   logic                 pop, pop_ok, push_ok, latch_full;
   logic [31:0]          head, status;
   logic [1:0]           err_set;

   assign load_rise  = load_sy[1] & ~load_sy[2];
   assign load_fall  = ~load_sy[1] & load_sy[2];
   assign sck_rise   = sck_sy[1] & ~sck_sy[2];
   assign sck_fall   = ~sck_sy[1] & sck_sy[2];
   assign pop        = (state == IDLE) & load_fall;
   assign pop_ok     = pop & (level != '0);
   assign push_ok    = res_wr_en & ~res_full;
   assign head       = (level != '0) ? mem[rd_ptr] : 32'h0;
   assign level_nxt  = level + LW'(push_ok) - LW'(pop_ok);
   assign status     = {CHIP_ID, 5'd0, 3'(level_nxt), 8'd0, frame_cnt};
   assign latch_full = (state == LATCH) & (bit_cnt == FULL_CNT);
   assign err_set    = {res_wr_en & res_full, latch_full & ~work_rdy};

   // Two-flop pin synchronizers; the third stage keeps the previous synced value for edge detection
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         load_sy <= '0;
         sck_sy  <= '0;
         mosi_sy <= '0;
      end else begin
         load_sy <= {load_sy[1:0], load};
         sck_sy  <= {sck_sy[1:0], sck};
         mosi_sy <= {mosi_sy[0], mosi};
      end

   // State register; reset parks in ARM so a frame cut by reset is never latched
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= ARM;
      else     state <= state_nxt;

   // Next-state logic for the frame sequencer
   always_comb begin
      state_nxt = state;
      case (state)
         ARM:     if (load_sy[1]) state_nxt = IDLE;
         IDLE:    if (load_fall)  state_nxt = SHIFT;
         SHIFT:   if (load_rise)  state_nxt = LATCH;
         default: state_nxt = IDLE;
      endcase
   end

   // Result FIFO storage
   always_ff @(posedge clk)
      if (push_ok) mem[wr_ptr] <= res_din;

   // Result FIFO pointers, fill level and registered full flag
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         res_full <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         level    <= level_nxt;
         res_full <= (level_nxt == DEPTH);
      end

   // Shift path, miso pass-through, frame hand-off and sticky errors
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sr        <= '0;
         bit_cnt   <= '0;
         miso      <= 1'b1;
         frame_cnt <= '0;
         work_vld  <= 1'b0;
         work_dat  <= '0;
         err       <= '0;
      end else begin
         work_vld <= latch_full & work_rdy;
         err      <= (err & ~{2{err_clr}}) | err_set;
         if (latch_full & work_rdy) begin
            work_dat  <= sr;
            frame_cnt <= frame_cnt + 1'b1;
         end
         if (state == SHIFT) begin
            if (sck_rise) begin
               sr <= {sr[WORK_BITS-2:0], mosi_sy[1]};
               if (bit_cnt != FULL_CNT) bit_cnt <= bit_cnt + 1'b1;
            end
            if (sck_fall) miso <= sr[WORK_BITS-1];
         end else if (pop) begin
            bit_cnt <= '0;
            sr      <= {head, status, sr[WORK_BITS-65:0]};
            miso    <= head[31];
         end else miso <= 1'b1;
      end
endmodule

// File: tb/tb_api_slave.sv
// tb_api_slave: random frames through a solo chip and a two-chip chain against a delay-line model
module tb_api_slave;
   localparam int WB = 736;
   localparam int H  = 5;

   logic          clk = 0, rst = 1, load = 1, sck = 0, mosi = 0, work_rdy = 1, err_clr = 0;
   logic [2:0]    wr_en = '0;
   logic [31:0]   din = '0;
   logic [2:0]    miso, work_vld, res_full;
   logic [WB-1:0] work_dat [3];
   logic [1:0]    err [3];
   int            vld_cnt [3] = '{0, 0, 0};
   int            n_cmp = 0, n_bad = 0;

   logic [31:0]   m_fifo [3][4];
   int            m_lvl [3];
   logic [7:0]    m_fcnt [3];
   logic [1:0]    m_err [3];
   logic [WB-1:0] m_sr [3], m_kn [3], m_dat [3], m_datk [3];
   bit            m_vld [3];
   bit            hb [2*WB];
   bit            ob [3][2*WB], okb [3][2*WB], smp [3][2*WB];

   always #5 clk = ~clk;

   api_slave #(.CHIP_ID(8'hA5)) u_solo (
      .clk(clk), .rst(rst), .load(load), .sck(sck), .mosi(mosi), .miso(miso[0]),
      .work_vld(work_vld[0]), .work_dat(work_dat[0]), .work_rdy(work_rdy),
      .res_wr_en(wr_en[0]), .res_din(din), .res_full(res_full[0]), .err(err[0]), .err_clr(err_clr));
   api_slave #(.CHIP_ID(8'h11)) u_c1 (
      .clk(clk), .rst(rst), .load(load), .sck(sck), .mosi(mosi), .miso(miso[1]),
      .work_vld(work_vld[1]), .work_dat(work_dat[1]), .work_rdy(work_rdy),
      .res_wr_en(wr_en[1]), .res_din(din), .res_full(res_full[1]), .err(err[1]), .err_clr(err_clr));
   api_slave #(.CHIP_ID(8'h22)) u_c2 (
      .clk(clk), .rst(rst), .load(load), .sck(sck), .mosi(miso[1]), .miso(miso[2]),
      .work_vld(work_vld[2]), .work_dat(work_dat[2]), .work_rdy(work_rdy),
      .res_wr_en(wr_en[2]), .res_din(din), .res_full(res_full[2]), .err(err[2]), .err_clr(err_clr));

   // Count work_vld pulses per chip
   always @(posedge clk)
      for (int c = 0; c < 3; c++) if (work_vld[c]) vld_cnt[c] <= vld_cnt[c] + 1;

   function automatic logic [7:0] id(input int c);
      return c == 0 ? 8'hA5 : c == 1 ? 8'h11 : 8'h22;
   endfunction

   task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         m_lvl[c]  = 0;
         m_fcnt[c] = 8'd0;
         m_err[c]  = 2'b00;
         m_sr[c]   = '0;
         m_kn[c]   = '0;
         m_dat[c]  = '0;
         m_datk[c] = '1;
      end
   endtask

   // Each chip is a 736-bit delay line preloaded with {head, status, stale bits}
   task automatic model_frame(input int n, input bit rdy);
      for (int c = 0; c < 3; c++) begin
         logic [31:0]   hd;
         logic [WB-1:0] s0, k0;
         int            k;
         hd = 32'h0;
         if (m_lvl[c] > 0) begin
            hd = m_fifo[c][0];
            for (int i = 0; i < 3; i++) m_fifo[c][i] = m_fifo[c][i+1];
            m_lvl[c]--;
         end
         s0 = {hd, id(c), 5'd0, 3'(m_lvl[c]), 8'd0, m_fcnt[c], m_sr[c][WB-65:0]};
         k0 = {64'hFFFF_FFFF_FFFF_FFFF, m_kn[c][WB-65:0]};
         for (int i = 0; i < n; i++) begin
            ob[c][i]  = i < WB ? s0[WB-1-i] : (c == 2 ? ob[1][i-WB] : hb[i-WB]);
            okb[c][i] = i < WB ? k0[WB-1-i] : (c == 2 ? okb[1][i-WB] : 1'b1);
         end
         for (int j = 0; j < WB; j++) begin
            k = n + j;
            m_sr[c][WB-1-j] = k < WB ? s0[WB-1-k] : (c == 2 ? ob[1][k-WB] : hb[k-WB]);
            m_kn[c][WB-1-j] = k < WB ? k0[WB-1-k] : (c == 2 ? okb[1][k-WB] : 1'b1);
         end
         m_vld[c] = (n >= WB) && rdy;
         if (m_vld[c]) begin
            m_dat[c]  = m_sr[c];
            m_datk[c] = m_kn[c];
            m_fcnt[c]++;
         end else if (n >= WB) m_err[c][0] = 1'b1;
      end
   endtask

   task automatic rand_bits(input int n);
      for (int k = 0; k < n; k++) hb[k] = $urandom_range(1, 0) != 0;
   endtask

   task automatic shift(input int n);
      for (int k = 0; k < n; k++) begin
         mosi = hb[k];
         repeat (H) @(negedge clk);
         for (int c = 0; c < 3; c++) smp[c][k] = miso[c];
         sck = 1;
         repeat (H) @(negedge clk);
         sck = 0;
      end
   endtask

   task automatic push(input int c, input logic [31:0] d);
      din = d;
      wr_en[c] = 1'b1;
      @(negedge clk);
      wr_en[c] = 1'b0;
      @(negedge clk);
      if (m_lvl[c] == 4) m_err[c][1] = 1'b1;
      else begin
         m_fifo[c][m_lvl[c]] = d;
         m_lvl[c]++;
      end
   endtask

   task automatic frame(input int n, input bit rdy);
      int v0 [3];
      for (int c = 0; c < 3; c++) v0[c] = vld_cnt[c];
      work_rdy = rdy;
      load = 0;
      repeat (H) @(negedge clk);
      shift(n);
      repeat (H) @(negedge clk);
      load = 1;
      repeat (12) @(negedge clk);
      model_frame(n, rdy);
      for (int c = 0; c < 3; c++) begin
         for (int w = 0; w < n / 32; w++) begin
            logic [31:0] ow, ew, mw;
            for (int i = 0; i < 32; i++) begin
               ow[31-i] = smp[c][32*w+i];
               ew[31-i] = ob[c][32*w+i];
               mw[31-i] = okb[c][32*w+i];
            end
            if (mw != 0) check($sformatf("miso c%0d w%0d", c, w), WB'(ow & mw), WB'(ew & mw));
         end
         check($sformatf("vld c%0d", c), WB'(vld_cnt[c] - v0[c]), WB'(m_vld[c]));
         check($sformatf("dat c%0d", c), work_dat[c] & m_datk[c], m_dat[c] & m_datk[c]);
         check($sformatf("err c%0d", c), WB'(err[c]), WB'(m_err[c]));
         check($sformatf("full c%0d", c), WB'(res_full[c]), WB'(m_lvl[c] == 4));
      end
   endtask

   initial begin
      logic [31:0] w2;
      int          v0 [3];
      repeat (3) @(negedge clk);
      rst = 0;
      model_reset();
      repeat (4) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("rst miso c%0d", c), WB'(miso[c]), WB'(1));
         check($sformatf("rst vld c%0d", c), WB'(work_vld[c]), WB'(0));
         check($sformatf("rst dat c%0d", c), work_dat[c], '0);
         check($sformatf("rst full c%0d", c), WB'(res_full[c]), WB'(0));
         check($sformatf("rst err c%0d", c), WB'(err[c]), WB'(0));
      end
      rand_bits(WB);
      w2 = 32'h1234_5678;
      for (int i = 0; i < 32; i++) hb[64+i] = w2[31-i];
      frame(WB, 1);
      push(0, 32'hDEAD_BEEF);
      check("full after one push", WB'(res_full[0]), WB'(0));
      rand_bits(WB);
      frame(WB, 1);
      push(1, 32'hC1C1_0001);
      push(2, 32'hC2C2_0002);
      rand_bits(2 * WB);
      frame(2 * WB, 1);
      for (int i = 0; i < 5; i++) begin
         push(0, $urandom());
         check($sformatf("full push%0d", i), WB'(res_full[0]), WB'(i >= 3));
      end
      check("err overflow", WB'(err[0]), WB'(2'b10));
      for (int i = 0; i < 5; i++) begin
         rand_bits(64);
         frame(64, 1);
      end
      rand_bits(WB);
      frame(WB, 0);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         m_err[c] = 2'b00;
         check($sformatf("err_clr c%0d", c), WB'(err[c]), WB'(0));
      end
      for (int c = 0; c < 3; c++) v0[c] = vld_cnt[c];
      rand_bits(300);
      load = 0;
      repeat (H) @(negedge clk);
      shift(300);
      rst = 1;
      repeat (3) @(negedge clk);
      rst = 0;
      model_reset();
      repeat (H) @(negedge clk);
      load = 1;
      repeat (12) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("cut vld c%0d", c), WB'(vld_cnt[c] - v0[c]), WB'(0));
         check($sformatf("cut err c%0d", c), WB'(err[c]), WB'(0));
         check($sformatf("cut miso c%0d", c), WB'(miso[c]), WB'(1));
      end
      rand_bits(WB);
      frame(WB, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
